// File: rtl/dvi_pkg.sv
// Shared TMDS definitions: symbol/disparity widths, control tokens, pixel layout
// and the transition-minimisation helpers used by every channel encoder.
package dvi_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NCNT_W = 4;

  localparam logic [SYM_W-1:0] CTRL_TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOK_11 = 10'b1010101011;

  // Channel mapping: ch2 = red, ch1 = green, ch0 = blue (+ sync)
  typedef struct packed {
    logic [DATA_W-1:0] red;
    logic [DATA_W-1:0] green;
    logic [DATA_W-1:0] blue;
  } rgb_pix_t;

  function automatic logic [SYM_W-1:0] ctrl_token(input logic [1:0] c);
    logic [SYM_W-1:0] tok;
    case (c)
      2'b01:   tok = CTRL_TOK_01;
      2'b10:   tok = CTRL_TOK_10;
      2'b11:   tok = CTRL_TOK_11;
      default: tok = CTRL_TOK_00;
    endcase
    return tok;
  endfunction

  function automatic logic [NCNT_W-1:0] popcount8(input logic [DATA_W-1:0] d);
    logic [NCNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(DATA_W); i++) n = n + NCNT_W'(d[i]);
    return n;
  endfunction

  // Stage-1 transition minimisation; bit 8 set means XOR mode was used
  function automatic logic [DATA_W:0] tm_encode(input logic [DATA_W-1:0] d);
    logic [DATA_W:0]   q;
    logic [NCNT_W-1:0] n;
    logic              use_xnor;
    n        = popcount8(d);
    use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q        = '0;
    q[0]     = d[0];
    for (int i = 1; i < int'(DATA_W); i++)
      q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[DATA_W] = ~use_xnor;
    return q;
  endfunction

endpackage

// File: rtl/tmds_channel_encoder.sv
// One TMDS lane: registered transition minimisation followed by a registered
// DC-balancing stage that owns the lane's running disparity.
module tmds_channel_encoder
  import dvi_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_c0,
  input  logic              i_c1,
  input  logic              i_de,
  output logic [SYM_W-1:0]  o_sym
);

  logic [DATA_W:0]          w_qm;
  logic [DATA_W:0]          r_qm;
  logic [NCNT_W-1:0]        r_n1;
  logic                     r_de;
  logic [1:0]               r_ctrl;
  logic signed [CNT_W-1:0]  r_cnt;
  logic signed [CNT_W-1:0]  w_cnt_nxt;
  logic signed [CNT_W-1:0]  w_diff;
  logic signed [CNT_W-1:0]  w_two_q8;
  logic signed [CNT_W-1:0]  w_two_nq8;
  logic [SYM_W-1:0]         w_sym_nxt;
  logic [SYM_W-1:0]         r_sym;

  assign w_qm = tm_encode(i_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qm   <= '0;
      r_n1   <= '0;
      r_de   <= 1'b0;
      r_ctrl <= 2'b00;
    end else begin
      r_qm   <= w_qm;
      r_n1   <= popcount8(w_qm[DATA_W-1:0]);
      r_de   <= i_de;
      r_ctrl <= {i_c1, i_c0};
    end
  end

  // N1 - N0 = 2*N1 - 8
  assign w_diff    = $signed({r_n1, 1'b0}) - 5'sd8;
  assign w_two_q8  = $signed({3'b000, r_qm[DATA_W], 1'b0});
  assign w_two_nq8 = $signed({3'b000, ~r_qm[DATA_W], 1'b0});

  always_comb begin
    w_sym_nxt = ctrl_token(r_ctrl);
    w_cnt_nxt = '0;
    if (r_de) begin
      if ((r_cnt == '0) || (r_n1 == 4'd4)) begin
        w_sym_nxt = {~r_qm[DATA_W], r_qm[DATA_W],
                     r_qm[DATA_W] ? r_qm[DATA_W-1:0] : ~r_qm[DATA_W-1:0]};
        w_cnt_nxt = r_qm[DATA_W] ? (r_cnt + w_diff) : (r_cnt - w_diff);
      end else if (r_cnt[CNT_W-1] == w_diff[CNT_W-1]) begin
        // Disparity and this word lean the same way: invert to pull back
        w_sym_nxt = {1'b1, r_qm[DATA_W], ~r_qm[DATA_W-1:0]};
        w_cnt_nxt = r_cnt + w_two_q8 - w_diff;
      end else begin
        w_sym_nxt = {1'b0, r_qm[DATA_W], r_qm[DATA_W-1:0]};
        w_cnt_nxt = r_cnt - w_two_nq8 + w_diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sym <= CTRL_TOK_00;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_sym <= w_sym_nxt;
    end
  end

  assign o_sym = r_sym;

endmodule

// File: rtl/dvi_tmds_encoder.sv
// Three-lane DVI TMDS encoder: splits the pixel into colour lanes and carries
// hsync/vsync as C0/C1 on the blue lane; fixed two-cycle latency.
module dvi_tmds_encoder
  import dvi_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [23:0]      rgb,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             vde,
  output logic [SYM_W-1:0] tmds_ch0,
  output logic [SYM_W-1:0] tmds_ch1,
  output logic [SYM_W-1:0] tmds_ch2
);

  rgb_pix_t w_pix;

  assign w_pix = rgb;

  tmds_channel_encoder u_ch0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_pix.blue),
    .i_c0   (hsync),
    .i_c1   (vsync),
    .i_de   (vde),
    .o_sym  (tmds_ch0)
  );

  tmds_channel_encoder u_ch1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_pix.green),
    .i_c0   (1'b0),
    .i_c1   (1'b0),
    .i_de   (vde),
    .o_sym  (tmds_ch1)
  );

  tmds_channel_encoder u_ch2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_pix.red),
    .i_c0   (1'b0),
    .i_c1   (1'b0),
    .i_de   (vde),
    .o_sym  (tmds_ch2)
  );

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Bench for dvi_tmds_encoder: hand-derived vector table, reset corner cases and
// random pixels compared against a behavioural DVI encoder model.
module tb_dvi_tmds_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [23:0] rgb = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        vde = 1'b0;
  logic [9:0]  tmds_ch0, tmds_ch1, tmds_ch2;

  int n_err = 0;
  int n_chk = 0;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T10  = 10'b0101010100;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] D00  = 10'b0100000000;
  localparam logic [9:0] DINV = 10'b1111111111;
  localparam logic [9:0] DFF  = 10'b1000000000;

  typedef struct {
    logic [23:0] rgb;
    bit          hs;
    bit          vs;
    bit          de;
  } pix_t;

  typedef struct {
    logic [23:0] rgb;
    bit          hs;
    bit          vs;
    bit          de;
    logic [9:0]  e0;
    logic [9:0]  e1;
    logic [9:0]  e2;
  } vec_t;

  // Model state: the pixel waiting in the pipeline and per-lane disparity
  pix_t m_s1;
  int   m_cnt [3];

  dvi_tmds_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rgb      (rgb),
    .hsync    (hsync),
    .vsync    (vsync),
    .vde      (vde),
    .tmds_ch0 (tmds_ch0),
    .tmds_ch1 (tmds_ch1),
    .tmds_ch2 (tmds_ch2)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [9:0] tok(input bit c1, input bit c0);
    if (!c1 && !c0) return T00;
    if (!c1 &&  c0) return T01;
    if ( c1 && !c0) return T10;
    return T11;
  endfunction

  function automatic logic [9:0] model_chan(input int ch, input logic [7:0] d,
                                            input bit de, input bit c1, input bit c0);
    int         n1d, n1, n0;
    bit         xn, q8;
    logic [7:0] qm;
    logic [9:0] s;
    if (!de) begin
      m_cnt[ch] = 0;
      return tok(c1, c0);
    end
    n1d = $countones(d);
    xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm  = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !xn;
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (m_cnt[ch] == 0 || n1 == n0) begin
      s = {~q8, q8, q8 ? qm : ~qm};
      m_cnt[ch] += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((m_cnt[ch] > 0 && n1 > n0) || (m_cnt[ch] < 0 && n0 > n1)) begin
      s = {1'b1, q8, ~qm};
      m_cnt[ch] += (q8 ? 2 : 0) + (n0 - n1);
    end else begin
      s = {1'b0, q8, qm};
      m_cnt[ch] += -(q8 ? 0 : 2) + (n1 - n0);
    end
    return s;
  endfunction

  task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1  = '{24'h0, 1'b0, 1'b0, 1'b0};
    m_cnt = '{0, 0, 0};
  endtask

  // Advance one clock and compare all lanes against the model
  task automatic tick(input string tag);
    logic [9:0] e0, e1, e2;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      e0 = T00; e1 = T00; e2 = T00;
      model_reset();
    end else begin
      e0 = model_chan(0, m_s1.rgb[7:0],   m_s1.de, m_s1.vs, m_s1.hs);
      e1 = model_chan(1, m_s1.rgb[15:8],  m_s1.de, 1'b0, 1'b0);
      e2 = model_chan(2, m_s1.rgb[23:16], m_s1.de, 1'b0, 1'b0);
      m_s1 = '{rgb, hsync, vsync, vde};
    end
    check({tag, "/ch0"}, tmds_ch0, e0);
    check({tag, "/ch1"}, tmds_ch1, e1);
    check({tag, "/ch2"}, tmds_ch2, e2);
  endtask

  task automatic drive_random(input bit force_de);
    rgb   = 24'($urandom());
    hsync = 1'($urandom_range(0, 1));
    vsync = 1'($urandom_range(0, 1));
    vde   = force_de ? 1'b1 : ($urandom_range(0, 3) != 0);
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{24'h000000, 1, 0, 0, T01,  T00,  T00};
    tbl[1]  = '{24'h000000, 1, 1, 0, T11,  T00,  T00};
    tbl[2]  = '{24'h000000, 0, 1, 0, T10,  T00,  T00};
    tbl[3]  = '{24'h000000, 0, 0, 1, D00,  D00,  D00};
    tbl[4]  = '{24'h000000, 1, 1, 1, DINV, DINV, DINV};
    tbl[5]  = '{24'h000000, 0, 0, 1, D00,  D00,  D00};
    tbl[6]  = '{24'h000000, 0, 0, 0, T00,  T00,  T00};
    tbl[7]  = '{24'hFFFFFF, 0, 0, 1, DFF,  DFF,  DFF};
    tbl[8]  = '{24'h000000, 0, 0, 0, T00,  T00,  T00};
    tbl[9]  = '{24'h000000, 0, 0, 1, D00,  D00,  D00};
    tbl[10] = '{24'h000000, 0, 0, 0, T00,  T00,  T00};

    model_reset();
    rst_n = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      drive_random(1'b0);
      tick("rst_hold");
    end

    // Release mid-cycle; pipeline still flushes the reset token
    #3;
    rst_n = 1'b1;
    drive_random(1'b1);
    #1;
    check("rel0/ch0", tmds_ch0, T00);
    check("rel0/ch1", tmds_ch1, T00);
    check("rel0/ch2", tmds_ch2, T00);
    tick("rel1");
    check("rel1_tok/ch0", tmds_ch0, T00);
    check("rel1_tok/ch2", tmds_ch2, T00);
    drive_random(1'b1);
    tick("rel2");

    // Vector table; each row's symbol appears one tick after it is clocked in
    for (int i = 0; i < 11; i++) begin
      rgb = tbl[i].rgb; hsync = tbl[i].hs; vsync = tbl[i].vs; vde = tbl[i].de;
      tick("tbl_model");
      if (i > 0) begin
        check($sformatf("tbl%0d/ch0", i - 1), tmds_ch0, tbl[i-1].e0);
        check($sformatf("tbl%0d/ch1", i - 1), tmds_ch1, tbl[i-1].e1);
        check($sformatf("tbl%0d/ch2", i - 1), tmds_ch2, tbl[i-1].e2);
      end
    end
    tick("tbl_model");
    check("tbl10/ch0", tmds_ch0, tbl[10].e0);
    check("tbl10/ch1", tmds_ch1, tbl[10].e1);
    check("tbl10/ch2", tmds_ch2, tbl[10].e2);

    // Random pixels against the model
    for (int i = 0; i < 5000; i++) begin
      drive_random(1'b0);
      tick("rnd_a");
    end

    // Asynchronous reset asserted mid-frame
    drive_random(1'b1);
    tick("pre_async");
    drive_random(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async/ch0", tmds_ch0, T00);
    check("async/ch1", tmds_ch1, T00);
    check("async/ch2", tmds_ch2, T00);
    drive_random(1'b1);
    tick("async_hold");
    #3;
    rst_n = 1'b1;
    drive_random(1'b1);
    tick("async_rel1");
    check("async_rel1_tok/ch1", tmds_ch1, T00);

    for (int i = 0; i < 5000; i++) begin
      drive_random(1'b0);
      tick("rnd_b");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dvi_tmds_encoder.md
# dvi_tmds_encoder

Three-channel DVI 1.0 TMDS encoder that converts the pixel stream produced by the RGB generator (24-bit RGB, hsync, vsync, vde) into three 10-bit TMDS symbols per pixel clock. Sits directly downstream of the RGB generator and upstream of the 10:1 serializers and output buffers in the HDMI output path. Fully pipelined, one pixel per cycle, fixed latency, with per-channel running-disparity tracking for DC balance.

## Interface
- No parameters.
- clk  in  1  pixel clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rgb  in  24  pixel {red[23:16], green[15:8], blue[7:0]}, sampled when vde=1.
- hsync  in  1  horizontal sync; carried as C0 on channel 0.
- vsync  in  1  vertical sync; carried as C1 on channel 0.
- vde  in  1  video data enable; 1 = active pixel, 0 = blanking.
- tmds_ch0  out  10  blue / sync channel symbol, bit 0 transmitted first.
- tmds_ch1  out  10  green channel symbol.
- tmds_ch2  out  10  red channel symbol.

## Operation
- Three identical channel encoders: ch0 {data=blue, C1=vsync, C0=hsync}; ch1 {green, 0, 0}; ch2 {red, 0, 0}.
- Stage 1 (transition minimisation), per channel with data D[7:0]:
  - n1d = popcount(D), 4 bits unsigned.
  - XNOR mode if n1d>4 or (n1d==4 and D[0]==0): q_m[0]=D[0], q_m[i]=~(q_m[i-1]^D[i]), q_m[8]=0.
  - otherwise XOR mode: q_m[i]=q_m[i-1]^D[i], q_m[8]=1.
  - Register q_m[8:0], N1=popcount(q_m[7:0]), N0=8-N1, delayed vde, delayed {C1,C0}.
- Stage 2 (DC balance), cnt = 5-bit signed running disparity per channel:
  - vde=0: output control token — {C1,C0}=00: 1101010100; 01: 0010101011; 10: 0101010100; 11: 1010101011. cnt <= 0.
  - vde=1, cnt==0 or N1==N0: out={~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}; cnt <= cnt + (q_m[8] ? N1-N0 : N0-N1).
  - vde=1, (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out={1, q_m[8], ~q_m[7:0]}; cnt <= cnt + 2*q_m[8] + (N0-N1).
  - vde=1, otherwise: out={0, q_m[8], q_m[7:0]}; cnt <= cnt - 2*(~q_m[8]) + (N1-N0).
- All disparity arithmetic is signed 5-bit; the DVI algorithm keeps |cnt| well inside range, so no saturation is implemented.
- vde transition 1->0 clears cnt on the first blanking cycle; transition 0->1 starts from cnt=0.

## Timing
- Latency: exactly 2 clk cycles from input sample to tmds_chN update; throughput 1 symbol/cycle/channel; no stalls, no handshake.
- hsync/vsync/vde are delayed through the same pipeline as data; channel alignment is exact (all three symbols from the same input cycle appear together).
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream): stage-1 vde=0, {C1,C0}=00, q_m=0; cnt=0 on all channels; tmds_ch0/1/2 = 1101010100.
- Reset asserted mid-frame: outputs go to 1101010100 immediately; the first two cycles after release emit 1101010100 regardless of input.

## Structure
- Shared package dvi_pkg: the four control-token constants, channel-to-colour mapping, symbol width (10), disparity width (5).
- One sub-module, tmds_channel_encoder (data[7:0], c0, c1, de in; 10-bit symbol out; its own cnt), instantiated three times; the top level only splits rgb and ties ch1/ch2 control bits to 0.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 1101010100; after release, first two outputs still 1101010100.
- Blanking: vde=0, hsync=1, vsync=0 -> two cycles later tmds_ch0=0010101011, tmds_ch1=tmds_ch2=1101010100; hsync=vsync=1 -> ch0=1010101011.
- Disparity sequence: vde=1, rgb=0x000000 for three cycles from cnt=0 -> each channel emits 0100000000, 1111111111, 0100000000 (cnt -8, +2, -6).
- XNOR path: rgb=0xFFFFFF first active pixel after blanking -> each channel emits 1000000000, cnt=-8.
- Mid-line blanking: active pixels with cnt≠0, then vde=0 for one cycle, then 0x000000 -> control token, then 0100000000 (cnt restarted at 0).
- Random: 10,000 random pixels with random vde/hsync/vsync -> bit-exact match against the behavioural DVI model, 2-cycle aligned, on all three channels.
